// File: rtl/fifo_rd_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_pkg
// Shared types and helpers for the FIFO read-side packer.
//   state_t    : packer control state (S_FILL collects words, S_HOLD waits to
//                hand the completed accumulator to the output register)
//   cnt_width  : width of a counter that must hold 0..pack_n inclusive
// Optional feature macro used by the files importing this package:
//   FIFO_RD_PACKER_FLUSH_EN
// -----------------------------------------------------------------------------
package fifo_rd_packer_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    function automatic int cnt_width(input int pack_n);
        return $clog2(pack_n + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Bundles the FIFO read port and the packed valid/ready output stream.
//   emp_fg    : FIFO empty flag            (environment -> packer)
//   rd_en     : FIFO read strobe           (packer -> environment)
//   rdata     : FIFO read data, DATA_W     (environment -> packer)
//   out_data  : packed word, DATA_W*PACK_N (packer -> environment)
//   out_valid : out_data holds a packet    (packer -> environment)
//   out_ready : consumer accepts out_data  (environment -> packer)
// With FIFO_RD_PACKER_FLUSH_EN defined, also:
//   flush     : request a partial packet   (environment -> packer)
//   out_cnt   : words held in out_data     (packer -> environment)
// Modports: master = packer side, slave = FIFO/consumer side.
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
    parameter int DATA_W = 3,
    parameter int PACK_N = 4
);
    import fifo_rd_packer_pkg::*;

    localparam int OUT_W = DATA_W * PACK_N;

    logic              emp_fg;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam int CNT_W = cnt_width(PACK_N);

    logic              flush;
    logic [CNT_W-1:0]  out_cnt;

    modport master (
        input  emp_fg, rdata, out_ready, flush,
        output rd_en, out_data, out_valid, out_cnt
    );

    modport slave (
        output emp_fg, rdata, out_ready, flush,
        input  rd_en, out_data, out_valid, out_cnt
    );
`else
    modport master (
        input  emp_fg, rdata, out_ready,
        output rd_en, out_data, out_valid
    );

    modport slave (
        output emp_fg, rdata, out_ready,
        input  rd_en, out_data, out_valid
    );
`endif

endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// -----------------------------------------------------------------------------
// pack_out_reg
// Single-entry valid/ready output register. Loads a new payload whenever it is
// empty or its current payload is being consumed in the same cycle, so a
// consume and a load can coincide without a bubble on out_valid.
//   clk, rst  : clock, synchronous active-high reset
//   load      : write load_data (only asserted while can_load is high)
//   load_data : payload to register, W bits
//   out_ready : consumer accepts out_data this cycle
//   out_data  : registered payload, held stable until consumed
//   out_valid : out_data holds an unconsumed payload
//   can_load  : register is free this cycle (!out_valid || out_ready)
// -----------------------------------------------------------------------------
module pack_out_reg #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         can_load
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    assign can_load  = !valid_reg || out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            // Consumed (or already empty): data is left as is, only valid drops.
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Drains narrow words from a 1-cycle-latency FIFO read port and packs PACK_N
// consecutive words into one wide word on a valid/ready output. The first word
// read lands in out_data[DATA_W-1:0]. The accumulator is separate from the
// output register, so the next packet fills while the current one is stalled
// by backpressure.
// Ports:
//   clk  : system clock (rising edge)
//   rst  : synchronous, active-high reset; discards any word in flight
//   bus  : fifo_rd_packer_if.master (emp_fg/rd_en/rdata, out_data/out_valid/
//          out_ready, plus flush/out_cnt when enabled)
// Parameters: DATA_W word width, PACK_N words per packet (PACK_N >= 2).
// Optional feature: define FIFO_RD_PACKER_FLUSH_EN to add a flush request that
// emits a zero-padded partial packet, and out_cnt reporting the word count.
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int PACK_N = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_rd_packer_if.master bus
);

    localparam int OUT_W = DATA_W * PACK_N;
    localparam int CNT_W = cnt_width(PACK_N);
`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam int PAYLOAD_W = OUT_W + CNT_W;
`else
    localparam int PAYLOAD_W = OUT_W;
`endif

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 pend_reg;
    logic [OUT_W-1:0]     acc_reg;
    logic [CNT_W:0]       inflight;
    logic                 rd_en;
    logic                 read_block;
    logic                 load;
    logic                 can_load;
    logic [PACK_N-1:0]    slot_we;
    logic [PAYLOAD_W-1:0] load_payload;
    logic [PAYLOAD_W-1:0] out_payload;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic flush_reg, flush_next, flush_take;

    // A flush is only meaningful if at least one word is captured or on its way.
    assign flush_take = bus.flush && (state_reg == S_FILL) && ((cnt_reg != '0) || pend_reg);
    assign read_block = flush_reg || flush_take;
`else
    assign read_block = 1'b0;
`endif

    // Words captured plus the one still in the FIFO read pipeline; reads stop
    // as soon as the packet is fully spoken for.
    assign inflight = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, pend_reg};
    assign rd_en    = !rst && !bus.emp_fg && (state_reg == S_FILL)
                   && (inflight < (CNT_W+1)'(PACK_N)) && !read_block;
    assign bus.rd_en = rd_en;

    // One write enable per accumulator slot: the returning word goes to slot cnt.
    for (genvar gi = 0; gi < PACK_N; gi++) begin : g_slot
        assign slot_we[gi] = pend_reg && (state_reg == S_FILL) && (cnt_reg == CNT_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        flush_next = flush_reg;
`endif
        case (state_reg)
            S_FILL: begin
                if (pend_reg) begin
                    cnt_next = cnt_reg + 1'b1;
                end
`ifdef FIFO_RD_PACKER_FLUSH_EN
                if (flush_take) begin
                    flush_next = 1'b1;
                end
                // Reads are blocked while flushing, so once the last in-flight
                // word has landed the partial packet is complete.
                if (flush_reg && !pend_reg) begin
                    state_next = S_HOLD;
                end
`endif
                if (cnt_next == CNT_W'(PACK_N)) begin
                    state_next = S_HOLD;
                end
`ifdef FIFO_RD_PACKER_FLUSH_EN
                if (state_next == S_HOLD) begin
                    flush_next = 1'b0;
                end
`endif
            end
            S_HOLD: begin
                if (can_load) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = S_FILL;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FILL;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            acc_reg   <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            flush_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= rd_en;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            flush_reg <= flush_next;
`endif
            if (load) begin
                // Cleared on hand-off so a later partial packet is zero padded.
                acc_reg <= '0;
            end else begin
                for (int i = 0; i < PACK_N; i++) begin
                    if (slot_we[i]) begin
                        acc_reg[i*DATA_W +: DATA_W] <= bus.rdata;
                    end
                end
            end
        end
    end

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // In S_HOLD cnt_reg is the number of words in the accumulator.
    assign load_payload = {cnt_reg, acc_reg};
    assign bus.out_data = out_payload[OUT_W-1:0];
    assign bus.out_cnt  = out_payload[PAYLOAD_W-1:OUT_W];
`else
    assign load_payload = acc_reg;
    assign bus.out_data = out_payload;
`endif

    pack_out_reg #(
        .W(PAYLOAD_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_payload),
        .out_ready (bus.out_ready),
        .out_data  (out_payload),
        .out_valid (bus.out_valid),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Bench for fifo_rd_packer. An 8-deep, 1-cycle-latency FIFO (syn_fifo
// behaviour) sits upstream and is fed through wr_en/wdata. Inputs are driven
// 1 time unit after the rising edge; handshakes are recorded on the falling
// edge. Define FIFO_RD_PACKER_FLUSH_EN to also exercise flush/out_cnt.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DATA_W = 3;
    localparam int PACK_N = 4;
    localparam int OUT_W  = DATA_W * PACK_N;
    localparam int DEPTH  = 8;

    typedef struct {
        int               first;
        int               n_words;
        logic             ready;
        int               n_pkt;
        logic [OUT_W-1:0] exp0;
        logic [OUT_W-1:0] exp1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_W(DATA_W), .PACK_N(PACK_N)) bus();

    fifo_rd_packer #(.DATA_W(DATA_W), .PACK_N(PACK_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Upstream FIFO: data appears on rdata the cycle after an accepted read.
    logic              wr_en;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [2:0]        wr_ptr;
    logic [2:0]        rd_ptr;
    int                fifo_cnt;

    assign bus.emp_fg = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= 0;
            bus.rdata <= '0;
        end else begin
            if (wr_en && fifo_cnt < DEPTH) begin
                fifo_mem[wr_ptr] <= wdata;
                wr_ptr           <= wr_ptr + 3'd1;
            end
            if (bus.rd_en && fifo_cnt != 0) begin
                bus.rdata <= fifo_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 3'd1;
            end
            fifo_cnt <= fifo_cnt + ((wr_en && fifo_cnt < DEPTH) ? 1 : 0)
                                 - ((bus.rd_en && fifo_cnt != 0) ? 1 : 0);
        end
    end

    // Handshake monitor and protocol watcher.
    int               cyc = 0;
    int               viol = 0;
    logic [OUT_W-1:0] got_q[$];
    int               got_t[$];
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic [2:0]       got_c[$];
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_t.push_back(cyc);
`ifdef FIFO_RD_PACKER_FLUSH_EN
            got_c.push_back(bus.out_cnt);
`endif
        end
        if (bus.rd_en && bus.emp_fg) begin
            viol <= viol + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wdata = DATA_W'((first + i) % 8);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        bus.flush = 1'b0;
`endif
        idle(2);
        rst = 1'b0;
        got_q.delete();
        got_t.delete();
`ifdef FIFO_RD_PACKER_FLUSH_EN
        got_c.delete();
`endif
    endtask

    task automatic wait_pkts(input string name, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, (got_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 timeouts", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   d;
        logic rd_seen;
        logic unstable;

        vecs[0] = '{first: 0, n_words: 8, ready: 1'b1, n_pkt: 2, exp0: 12'h688, exp1: 12'hFAC};
        vecs[1] = '{first: 4, n_words: 4, ready: 1'b1, n_pkt: 1, exp0: 12'hFAC, exp1: 12'h000};
        vecs[2] = '{first: 1, n_words: 4, ready: 1'b1, n_pkt: 1, exp0: 12'h8D1, exp1: 12'h000};
        vecs[3] = '{first: 2, n_words: 8, ready: 1'b1, n_pkt: 2, exp0: 12'hB1A, exp1: 12'h23E};

        wr_en         = 1'b0;
        wdata         = '0;
        bus.out_ready = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_rd_en", 32'(bus.rd_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven full-packet runs.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            bus.out_ready = vecs[v].ready;
            push(vecs[v].first, vecs[v].n_words);
            wait_pkts($sformatf("vec%0d_arrived", v), vecs[v].n_pkt, 80);
            idle(10);
            check($sformatf("vec%0d_pkt_count", v), 32'(got_q.size()), 32'(vecs[v].n_pkt));
            if (got_q.size() > 0)
                check($sformatf("vec%0d_pkt0", v), 32'(got_q[0]), 32'(vecs[v].exp0));
            if (got_q.size() > 1)
                check($sformatf("vec%0d_pkt1", v), 32'(got_q[1]), 32'(vecs[v].exp1));
`ifdef FIFO_RD_PACKER_FLUSH_EN
            if (got_c.size() > 0)
                check($sformatf("vec%0d_out_cnt", v), 32'(got_c[0]), PACK_N);
`endif
        end

        // Backpressure: first packet held, second parked in the accumulator.
        do_reset();
        bus.out_ready = 1'b0;
        push(0, 8);
        idle(20);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_out_data", 32'(bus.out_data), 32'h688);
        check("bp_fifo_drained", 32'(fifo_cnt), 32'd0);
        check("bp_acc_full_cnt", 32'(dut.cnt_reg), 32'd4);
        push(3, 1);
        rd_seen  = 1'b0;
        unstable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_en) rd_seen = 1'b1;
            if (bus.out_data !== 12'h688 || bus.out_valid !== 1'b1) unstable = 1'b1;
            idle(1);
        end
        check("bp_no_read_while_full", 32'(rd_seen), 32'd0);
        check("bp_data_stable", 32'(unstable), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd1);
        check("bp_release_data", 32'(bus.out_data), 32'h688);
        @(posedge clk);
        #1;
        check("bp_noBubble_valid", 32'(bus.out_valid), 32'd1);
        check("bp_noBubble_data", 32'(bus.out_data), 32'hFAC);
        @(posedge clk);
        #1;
        check("bp_drop_valid", 32'(bus.out_valid), 32'd0);
        idle(10);
        check("bp_pkt_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() > 1) begin
            check("bp_pkt0", 32'(got_q[0]), 32'h688);
            check("bp_pkt1", 32'(got_q[1]), 32'hFAC);
        end
        check("bp_extra_word_kept", 32'(dut.cnt_reg), 32'd1);

        // Back-to-back throughput with out_ready held high.
        do_reset();
        bus.out_ready = 1'b1;
        push(0, 8);
        wait_pkts("tput_arrived", 2, 80);
        idle(5);
        if (got_t.size() > 1) begin
            d = got_t[1] - got_t[0];
            check("tput_interval_in_range", (d >= PACK_N + 1 && d <= PACK_N + 2) ? 32'd1 : 32'd0, 32'd1);
        end

        // Starvation mid-packet: no partial packet, count holds.
        do_reset();
        bus.out_ready = 1'b1;
        push(0, 2);
        idle(15);
        check("starve_no_pkt", 32'(got_q.size()), 32'd0);
        check("starve_out_valid", 32'(bus.out_valid), 32'd0);
        check("starve_cnt", 32'(dut.cnt_reg), 32'd2);
        push(2, 2);
        wait_pkts("starve_resume_arrived", 1, 40);
        idle(10);
        check("starve_pkt_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0)
            check("starve_pkt0", 32'(got_q[0]), 32'h688);

        // Reset while a read is in flight.
        do_reset();
        bus.out_ready = 1'b1;
        push(0, 3);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fifo_cnt != 0 && k < 20);
        check("rstmid_pend_reached", 32'(dut.pend_reg), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid_out_data", 32'(bus.out_data), 32'd0);
        check("rstmid_cnt", 32'(dut.cnt_reg), 32'd0);
        check("rstmid_pend", 32'(dut.pend_reg), 32'd0);
        got_q.delete();
        got_t.delete();
`ifdef FIFO_RD_PACKER_FLUSH_EN
        got_c.delete();
`endif
        push(4, 4);
        wait_pkts("rstmid_arrived", 1, 40);
        idle(10);
        check("rstmid_pkt_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0)
            check("rstmid_pkt0", 32'(got_q[0]), 32'hFAC);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        // Flush with nothing captured is ignored; flush with two words emits them.
        do_reset();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        idle(10);
        check("flush_empty_ignored", 32'(got_q.size()), 32'd0);
        push(5, 2);
        idle(8);
        check("flush_before_pulse", 32'(got_q.size()), 32'd0);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        wait_pkts("flush_arrived", 1, 20);
        idle(5);
        check("flush_pkt_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            check("flush_pkt_data", 32'(got_q[0]), 32'h035);
            check("flush_out_cnt", 32'(got_c[0]), 32'd2);
        end
        push(0, 4);
        wait_pkts("flush_after_arrived", 2, 40);
        if (got_q.size() > 1) begin
            check("flush_after_data", 32'(got_q[1]), 32'h688);
            check("flush_after_cnt", 32'(got_c[1]), 32'd4);
        end
`endif

        check("rd_en_while_empty", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of syn_fifo. Drains narrow words through the FIFO read port (rd_en/rdata/emp_fg).
- Packs PACK_N consecutive words into one wide word and presents it on a valid/ready output.
- Accumulator and output register are separate, so the next packet fills while the current one waits on backpressure.

Parameters:
- DATA_W, 3, FIFO word width; matches syn_fifo fifo_width for an 8-deep FIFO.
- PACK_N, 4, words per packet; must be at least 2.
- OUT_W, DATA_W*PACK_N, packed output width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- emp_fg  in  1  FIFO empty flag.
- rd_en  out  1  FIFO read strobe.
- rdata  in  DATA_W  FIFO read data.
- out_data  out  OUT_W  packed word; first word read sits in bits [DATA_W-1:0].
- out_valid  out  1  out_data holds a packet.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- FIFO contract: rdata is valid the cycle after a clock edge where rd_en=1 and emp_fg=0 (1-cycle read latency).
- Internal state:
  - acc: OUT_W bits.
  - cnt: words captured, $clog2(PACK_N+1) bits.
  - pend: 1 bit; a read was issued last cycle.
  - state: S_FILL or S_HOLD.
- rd_en is combinational:
  - rd_en = !rst && !emp_fg && state==S_FILL && (cnt + pend) < PACK_N.
  - It is never asserted while the FIFO is empty.
- Capture: when pend=1, write rdata into acc slot cnt (bits cnt*DATA_W +: DATA_W) and increment cnt.
- pend <= rd_en each cycle.
- Transitions:
  - S_FILL -> S_HOLD when cnt reaches PACK_N.
  - In S_HOLD, transfer happens when !out_valid || out_ready:
    - out_data <= acc and out_valid <= 1.
    - cnt <= 0, state <= S_FILL.
    - rd_en may assert in that same cycle's successor.
- Output handshake:
  - A packet is consumed on any cycle with out_valid && out_ready.
  - With no new transfer, out_valid drops to 0 the next cycle.
  - out_data stays stable while out_valid && !out_ready.
- Back-to-back throughput: one packet per PACK_N+1 cycles minimum, given a non-empty FIFO and out_ready=1.
- Empty mid-packet: reads stall, cnt holds, and no partial packet is emitted. Filling resumes when emp_fg falls.
- Reset (synchronous, any state, including mid-packet or with pend=1):
  - out_valid=0, out_data=0, acc=0, cnt=0, pend=0, state=S_FILL.
  - rd_en is 0 in the reset cycle.
  - Data in flight is discarded.
- Ordering: words leave in FIFO order; no loss or duplication across backpressure.

Optional Feature:
- Macro FIFO_RD_PACKER_FLUSH_EN, when defined:
  - Adds input flush (1 bit) and output out_cnt ($clog2(PACK_N+1) bits).
  - A flush pulse in S_FILL with cnt>0 stops new reads and waits for pend to clear.
  - It then transfers a partial packet: unused slots are zero and out_cnt = words captured.
  - Full packets report out_cnt=PACK_N.
  - A flush pulse with cnt=0 and pend=0 is ignored.
- Without the macro: no flush or out_cnt ports; only full packets are produced.

Decomposition:
- Package fifo_rd_packer_pkg:
  - State enum type (S_FILL, S_HOLD).
  - Function computing the count width: $clog2(PACK_N+1).
- One natural sub-module, pack_out_reg: the single-entry valid/ready output register (load, hold, consume).
- The bench instantiates syn_fifo (fifo_depth=8) upstream, driving wr_en/wdata.

Test Plan:
- Full packets: after reset, write 0..7 into the FIFO with out_ready=1 → two packets, out_data=0x688 ({3,2,1,0}) then 0xFAC ({7,6,5,4}); rd_en never high while emp_fg=1.
- Backpressure: write 0..7 with out_ready=0 → out_valid=1, out_data=0x688 held stable; second packet fills acc and rd_en stays 0 afterwards. Raising out_ready yields 0xFAC next.
- Partial starvation: write only 0,1 → no out_valid and cnt=2. Write 2,3 later → a single packet 0x688.
- Reset mid-packet: write 0,1,2, assert rst one cycle while pend=1 → outputs cleared. Then write 4,5,6,7 → packet 0xFAC, with no stale words.
- Simultaneous consume/load: keep out_ready=1 with a continuously non-empty FIFO → a new packet loads on the exact cycle the previous one is consumed, with no bubble on out_valid beyond the fill time.
- Flush (with FIFO_RD_PACKER_FLUSH_EN): write 5,6, then pulse flush → out_data=0x035, out_cnt=2.
